// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: immediate-mode encodings and the
// ID/EX control bundle.
package decode_pkg;

  localparam logic [1:0] IMM_SEXT   = 2'b00;
  localparam logic [1:0] IMM_ZEXT   = 2'b01;
  localparam logic [1:0] IMM_UPPER  = 2'b10;
  localparam logic [1:0] IMM_BRANCH = 2'b11;

  typedef struct packed {
    logic valid;
    logic jump;
    logic reg_write;
    logic mem_read;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_CTRL_NONE = ex_ctrl_t'(4'b0000);

endpackage

// File: rtl/decode_stage_param_if.sv
// Decode-stage bus: IF/ID fields, control bits, write-back port and the
// ID/EX outputs. The master drives the decode side; the slave is the stage.
interface decode_stage_param_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int IMM_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic [IMM_W-1:0]  imm;
  logic [1:0]        imm_mode;
  logic              jump_in;
  logic              reg_write_cu;
  logic              mem_read_cu;
  logic              ex_stall;
  logic              flush;
  logic              wb_we;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              id_stall;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0] ex_rt;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_jump;
  logic              ex_reg_write;
  logic              ex_mem_read;

  modport master (
    output id_valid, rs, rt, rd, imm, imm_mode, jump_in, reg_write_cu, mem_read_cu,
           ex_stall, flush, wb_we, wb_addr, wb_data,
    input  id_stall, ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd,
           ex_jump, ex_reg_write, ex_mem_read
  );

  modport slave (
    input  id_valid, rs, rt, rd, imm, imm_mode, jump_in, reg_write_cu, mem_read_cu,
           ex_stall, flush, wb_we, wb_addr, wb_data,
    output id_stall, ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd,
           ex_jump, ex_reg_write, ex_mem_read
  );
endinterface

// File: rtl/regfile_bypass.sv
// Register file with two combinational read ports, one write port and
// same-cycle write-back bypass. Register 0 is hard-wired to zero.
module regfile_bypass #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);
  localparam int NREG = 2 ** REG_AW;

  logic [DATA_W-1:0] regs_r [NREG];

  function automatic logic [DATA_W-1:0] read_port(
    input logic [REG_AW-1:0] ra,
    input logic              w_en,
    input logic [REG_AW-1:0] wa,
    input logic [DATA_W-1:0] wd,
    input logic [DATA_W-1:0] stored
  );
    if (ra == {REG_AW{1'b0}}) begin
      return {DATA_W{1'b0}};
    end else if (w_en && (wa == ra)) begin
      return wd;
    end else begin
      return stored;
    end
  endfunction

  // Storage update; writes to register 0 are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else if (we && (waddr != {REG_AW{1'b0}})) begin
      regs_r[waddr] <= wdata;
    end
  end

  // Read ports with write-back bypass.
  always_comb begin
    rdata_a = read_port(raddr_a, we, waddr, wdata, regs_r[raddr_a]);
    rdata_b = read_port(raddr_b, we, waddr, wdata, regs_r[raddr_b]);
  end

endmodule

// File: rtl/decode_stage_param.sv
// Instruction-decode stage: register read with bypass, immediate extension,
// load-use detection and the stall/flush-controlled ID/EX register.
module decode_stage_param
  import decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int IMM_W  = 16
) (
  input logic                 clk,
  input logic                 reset,
  decode_stage_param_if.slave bus
);
  logic [DATA_W-1:0] rs_data_s;
  logic [DATA_W-1:0] rt_data_s;
  logic [DATA_W-1:0] imm_sext_s;
  logic [DATA_W-1:0] imm_ext_s;
  logic              load_use_s;
  ex_ctrl_t          ctrl_r;
  ex_ctrl_t          ctrl_cap_s;
  logic [DATA_W-1:0] rs_data_r;
  logic [DATA_W-1:0] rt_data_r;
  logic [DATA_W-1:0] imm_r;
  logic [REG_AW-1:0] rs_r;
  logic [REG_AW-1:0] rt_r;
  logic [REG_AW-1:0] rd_r;

  regfile_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rf (
    .clk     (clk),
    .reset   (reset),
    .we      (bus.wb_we),
    .waddr   (bus.wb_addr),
    .wdata   (bus.wb_data),
    .raddr_a (bus.rs),
    .raddr_b (bus.rt),
    .rdata_a (rs_data_s),
    .rdata_b (rt_data_s)
  );

  // Immediate extension by mode.
  always_comb begin
    imm_sext_s = {{(DATA_W-IMM_W){bus.imm[IMM_W-1]}}, bus.imm};
    case (bus.imm_mode)
      IMM_SEXT:   imm_ext_s = imm_sext_s;
      IMM_ZEXT:   imm_ext_s = {{(DATA_W-IMM_W){1'b0}}, bus.imm};
      IMM_UPPER:  imm_ext_s = {bus.imm, {(DATA_W-IMM_W){1'b0}}};
      IMM_BRANCH: imm_ext_s = {imm_sext_s[DATA_W-3:0], 2'b00};
      default:    imm_ext_s = imm_sext_s;
    endcase
  end

  // Hazard detection; rt is compared even for formats that do not read it.
  always_comb begin
    load_use_s = bus.id_valid & ctrl_r.valid & ctrl_r.mem_read
               & (rd_r != {REG_AW{1'b0}})
               & ((rd_r == bus.rs) | (rd_r == bus.rt));
    ctrl_cap_s.valid     = bus.id_valid;
    ctrl_cap_s.jump      = bus.jump_in & bus.id_valid;
    ctrl_cap_s.reg_write = bus.reg_write_cu & bus.id_valid;
    ctrl_cap_s.mem_read  = bus.mem_read_cu & bus.id_valid;
  end

  assign bus.id_stall = load_use_s | bus.ex_stall;

  // ID/EX register: flush beats stall, stall beats bubble; data holds on any of them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_r    <= EX_CTRL_NONE;
      rs_data_r <= {DATA_W{1'b0}};
      rt_data_r <= {DATA_W{1'b0}};
      imm_r     <= {DATA_W{1'b0}};
      rs_r      <= {REG_AW{1'b0}};
      rt_r      <= {REG_AW{1'b0}};
      rd_r      <= {REG_AW{1'b0}};
    end else if (bus.flush) begin
      ctrl_r <= EX_CTRL_NONE;
    end else if (bus.ex_stall) begin
      ctrl_r <= ctrl_r;
    end else if (load_use_s) begin
      ctrl_r <= EX_CTRL_NONE;
    end else begin
      ctrl_r    <= ctrl_cap_s;
      rs_data_r <= rs_data_s;
      rt_data_r <= rt_data_s;
      imm_r     <= imm_ext_s;
      rs_r      <= bus.rs;
      rt_r      <= bus.rt;
      rd_r      <= bus.rd;
    end
  end

  assign bus.ex_valid     = ctrl_r.valid;
  assign bus.ex_jump      = ctrl_r.jump;
  assign bus.ex_reg_write = ctrl_r.reg_write;
  assign bus.ex_mem_read  = ctrl_r.mem_read;
  assign bus.ex_rs_data   = rs_data_r;
  assign bus.ex_rt_data   = rt_data_r;
  assign bus.ex_imm       = imm_r;
  assign bus.ex_rs        = rs_r;
  assign bus.ex_rt        = rt_r;
  assign bus.ex_rd        = rd_r;

endmodule
